// File: rtl/regfile_op_sequencer_if.sv
// Command and register-file port bundle for regfile_op_sequencer.
// master = sequencer side, slave = command source plus register file.
interface regfile_op_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  CmdValid;
  logic                  CmdReady;
  logic [1:0]            CmdOp;
  logic [ADDR_WIDTH-1:0] CmdDest;
  logic [ADDR_WIDTH-1:0] CmdSrc1;
  logic [ADDR_WIDTH-1:0] CmdSrc2;
  logic [ADDR_WIDTH-1:0] ReadAddress1;
  logic [ADDR_WIDTH-1:0] ReadAddress2;
  logic [DATA_WIDTH-1:0] ReadValue1;
  logic [DATA_WIDTH-1:0] ReadValue2;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteValue;
  logic                  Carry;
  logic                  Zero;
  logic [7:0]            OpCount;

  modport master (
    input  CmdValid, CmdOp, CmdDest, CmdSrc1, CmdSrc2, ReadValue1, ReadValue2,
    output CmdReady, ReadAddress1, ReadAddress2, mode, WriteAddress, WriteValue,
           Carry, Zero, OpCount
  );

  modport slave (
    output CmdValid, CmdOp, CmdDest, CmdSrc1, CmdSrc2, ReadValue1, ReadValue2,
    input  CmdReady, ReadAddress1, ReadAddress2, mode, WriteAddress, WriteValue,
           Carry, Zero, OpCount
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Sequences one Dest <= Src1 op Src2 command through a 2-read/1-write register file.
// Optional macro ZERO_REG_EN: register 0 reads as zero and is never written.
module regfile_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  regfile_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t state;
  state_t stateNext;

  logic [1:0]            cmdOp_p0;
  logic [ADDR_WIDTH-1:0] cmdDest_p0;
  logic [DATA_WIDTH-1:0] opA_p1;
  logic [DATA_WIDTH-1:0] opB_p1;
  logic [DATA_WIDTH:0]   result;
  logic                  writeEn;
  logic                  accept;

  // Carry lands in the extra MSB; SUB carry is the no-borrow flag.
  function automatic logic [DATA_WIDTH:0] aluResult(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  assign accept       = (state == IDLE) && bus.CmdValid;
  assign bus.CmdReady = (state == IDLE) && !rst;
  assign result       = aluResult(cmdOp_p0, opA_p1, opB_p1);

`ifdef ZERO_REG_EN
  assign writeEn = (cmdDest_p0 != '0);
`else
  assign writeEn = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.CmdValid) stateNext = READ;
      READ:    stateNext = EXEC;
      EXEC:    stateNext = WRITE;
      default: stateNext = IDLE;
    endcase
  end

  // Stage p0: command latch at acceptance; stage p1: operand capture in READ
  always_ff @(posedge clk) begin
    if (accept) begin
      cmdOp_p0   <= bus.CmdOp;
      cmdDest_p0 <= bus.CmdDest;
    end
    if (state == READ) begin
`ifdef ZERO_REG_EN
      opA_p1 <= (bus.ReadAddress1 == '0) ? '0 : bus.ReadValue1;
      opB_p1 <= (bus.ReadAddress2 == '0) ? '0 : bus.ReadValue2;
`else
      opA_p1 <= bus.ReadValue1;
      opB_p1 <= bus.ReadValue2;
`endif
    end
  end

  // Stage p2: registered file-facing outputs and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ReadAddress1 <= '0;
      bus.ReadAddress2 <= '0;
      bus.mode         <= 1'b0;
      bus.WriteAddress <= '0;
      bus.WriteValue   <= '0;
      bus.Carry        <= 1'b0;
      bus.Zero         <= 1'b0;
      bus.OpCount      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CmdValid) begin
            bus.ReadAddress1 <= bus.CmdSrc1;
            bus.ReadAddress2 <= bus.CmdSrc2;
          end
        end
        EXEC: begin
          bus.WriteAddress <= cmdDest_p0;
          bus.WriteValue   <= result[DATA_WIDTH-1:0];
          bus.Carry        <= result[DATA_WIDTH];
          bus.Zero         <= (result[DATA_WIDTH-1:0] == '0);
          bus.mode         <= writeEn;
        end
        WRITE: begin
          bus.mode    <= 1'b0;
          bus.OpCount <= bus.OpCount + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench for regfile_op_sequencer with a behavioural register-file model.
module tb_regfile_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_op_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

  regfile_op_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [15:0] regs [32];
  logic        preEn = 1'b0;
  logic [4:0]  preAddr = '0;
  logic [15:0] preData = '0;

  assign bus.ReadValue1 = regs[bus.ReadAddress1];
  assign bus.ReadValue2 = regs[bus.ReadAddress2];

  always @(posedge clk) begin
    if (bus.mode) regs[bus.WriteAddress] <= bus.WriteValue;
    if (preEn)    regs[preAddr] <= preData;
  end

  int nChecks = 0;
  int nFail   = 0;
  int expCount = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [4:0]  dest, src1, src2;
    logic [15:0] a, b;
    logic [15:0] expVal;
    logic        expC, expZ, expWr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] addr, input logic [15:0] val);
    @(negedge clk);
    preEn = 1'b1; preAddr = addr; preData = val;
    @(negedge clk);
    preEn = 1'b0;
  endtask

  // Reference: plain arithmetic from the operation definitions.
  function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (op)
      2'b00:   return 17'(ia + ib);
      2'b01:   return {(ia >= ib), 16'((ia - ib) & 32'hFFFF)};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic [15:0] operand(input logic [4:0] addr);
`ifdef ZERO_REG_EN
    if (addr == 5'd0) return 16'h0000;
`endif
    return regs[addr];
  endfunction

  function automatic logic writes(input logic [4:0] d);
`ifdef ZERO_REG_EN
    return d != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic issue(input string nm, input logic [1:0] op, input logic [4:0] d, s1, s2,
                       input logic [15:0] ev, input logic ec, ez, ewr);
    int waitN = 0;
    @(negedge clk);
    while (!bus.CmdReady && waitN < 20) begin @(negedge clk); waitN++; end
    if (!bus.CmdReady) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.CmdValid = 1'b1; bus.CmdOp = op; bus.CmdDest = d; bus.CmdSrc1 = s1; bus.CmdSrc2 = s2;
    @(posedge clk);
    #1 bus.CmdValid = 1'b0;
    @(negedge clk);
    chk({nm, "_modeE0"}, bus.mode, 0);
    @(negedge clk);
    chk({nm, "_modeE1"}, bus.mode, 0);
    @(negedge clk);
    chk({nm, "_modeE2"}, bus.mode, ewr);
    chk({nm, "_value"}, bus.WriteValue, ev);
    chk({nm, "_carry"}, bus.Carry, ec);
    chk({nm, "_zero"}, bus.Zero, ez);
    if (ewr) chk({nm, "_waddr"}, bus.WriteAddress, d);
    @(negedge clk);
    expCount = (expCount + 1) % 256;
    chk({nm, "_modeE3"}, bus.mode, 0);
    chk({nm, "_opcount"}, bus.OpCount, expCount);
    chk({nm, "_readyE3"}, bus.CmdReady, 1);
    if (ewr) chk({nm, "_regfile"}, regs[d], ev);
  endtask

  vec_t vecs [8];

  initial begin
    int readyIdx [$];
    int modeHigh;
    logic [16:0] r;
    logic [15:0] keep;

    bus.CmdValid = 1'b0; bus.CmdOp = '0; bus.CmdDest = '0; bus.CmdSrc1 = '0; bus.CmdSrc2 = '0;

    vecs[0] = '{"add_basic", 2'b00, 5'd2, 5'd3, 5'd1, 16'h1232, 16'h1263, 16'h2495, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"add_wrap",  2'b00, 5'd6, 5'd4, 5'd5, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{"sub_borrow",2'b01, 5'd7, 5'd5, 5'd4, 16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"sub_nobor", 2'b01, 5'd8, 5'd4, 5'd5, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"and",       2'b10, 5'd9, 5'd10, 5'd11, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"or",        2'b11, 5'd12, 5'd10, 5'd11, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"src_eq_dst",2'b00, 5'd13, 5'd13, 5'd13, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
`ifdef ZERO_REG_EN
    vecs[7] = '{"reg0",      2'b00, 5'd0, 5'd0, 5'd1, 16'h0005, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0};
`else
    vecs[7] = '{"reg0",      2'b00, 5'd0, 5'd0, 5'd1, 16'h0005, 16'h0007, 16'h000C, 1'b0, 1'b0, 1'b1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.CmdReady, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_outs", {bus.WriteAddress, bus.WriteValue, bus.ReadAddress1, bus.ReadAddress2},
        32'h0);
    chk("rst_flags", {bus.Carry, bus.Zero, bus.OpCount}, 0);
    rst = 1'b0;
    #1 chk("rst_release_ready", bus.CmdReady, 1);

    for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));

    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].src1, vecs[i].a);
      preload(vecs[i].src2, vecs[i].b);
      issue(vecs[i].name, vecs[i].op, vecs[i].dest, vecs[i].src1, vecs[i].src2,
            vecs[i].expVal, vecs[i].expC, vecs[i].expZ, vecs[i].expWr);
    end

    // Back-to-back with CmdValid held high
    @(negedge clk);
    bus.CmdValid = 1'b1; bus.CmdOp = 2'b00; bus.CmdDest = 5'd20; bus.CmdSrc1 = 5'd21; bus.CmdSrc2 = 5'd22;
    modeHigh = 0;
    for (int c = 0; c < 13; c++) begin
      if (bus.CmdReady) readyIdx.push_back(c);
      if (bus.mode) modeHigh++;
      @(negedge clk);
    end
    bus.CmdValid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_accepts", readyIdx.size(), 4);
    for (int k = 1; k < readyIdx.size(); k++)
      chk("b2b_spacing", readyIdx[k] - readyIdx[k-1], 4);
    chk("b2b_pulses", modeHigh, 3);
    expCount = (expCount + 4) % 256;
    chk("b2b_opcount", bus.OpCount, expCount);

    // Reset during EXEC: no write, counter cleared and not advanced
    keep = regs[25];
    @(negedge clk);
    bus.CmdValid = 1'b1; bus.CmdOp = 2'b11; bus.CmdDest = 5'd25; bus.CmdSrc1 = 5'd26; bus.CmdSrc2 = 5'd27;
    @(posedge clk);
    #1 bus.CmdValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", bus.CmdReady, 0);
    chk("midrst_mode", bus.mode, 0);
    @(negedge clk);
    rst = 1'b0;
    modeHigh = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.mode) modeHigh++;
      @(negedge clk);
    end
    chk("midrst_nopulse", modeHigh, 0);
    chk("midrst_opcount", bus.OpCount, 0);
    chk("midrst_reg", regs[25], keep);
    expCount = 0;
    preload(5'd3, 16'h1000);
    preload(5'd4, 16'h0234);
    issue("after_rst", 2'b00, 5'd5, 5'd3, 5'd4, 16'h1234, 1'b0, 1'b0, 1'b1);

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [4:0] d, s1, s2;
      op = 2'($urandom); d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      if (n % 7 == 0) s2 = s1;
      @(negedge clk);
      r = model(op, operand(s1), operand(s2));
      issue("random", op, d, s1, s2, r[15:0], r[16], r[15:0] == 16'h0, writes(d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
